// File: rtl/btn_debounce_enc.sv
// Purpose: debounce raw buttons, emit press/release pulses, decode D/U/R/L into a move direction with auto-repeat step, and flag a long hold.
// Latency: raw edge to btn_db_o is DB_CYCLES+2 cycles; move_en_o/direct_o/step_o follow btn_db_o by one cycle.
// Backpressure: none, pulses are fire-and-forget single-cycle strobes.
//
// Ports:
//   clk, rst         - system clock, asynchronous active-high reset
//   btn_i            - raw active-high pins, asynchronous to clk
//   btn_db_o         - debounced levels; press_o / release_o pulse on debounced edges
//   move_en_o        - exactly one direction button held; direct_o gives which
//   step_o           - movement step strobe with auto-repeat
//   long_rst_o       - long-hold request on btn LONG_IDX (level or pulse by RST_MODE)

`ifndef UP
`define UP    2'b00
`endif
`ifndef DOWN
`define DOWN  2'b01
`endif
`ifndef LEFT
`define LEFT  2'b10
`endif
`ifndef RIGHT
`define RIGHT 2'b11
`endif

module btn_debounce_enc #(
    parameter int NUM_BTN     = 5,
    parameter int DB_CYCLES   = 1_000_000,
    parameter int LONG_CYCLES = 50_000_000,
    parameter int LONG_IDX    = 4,
    parameter int RPT_DELAY   = 25_000_000,
    parameter int RPT_PERIOD  = 5_000_000,
    parameter int RST_MODE    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic [NUM_BTN-1:0] btn_db_o,
    output logic [NUM_BTN-1:0] press_o,
    output logic [NUM_BTN-1:0] release_o,
    output logic               move_en_o,
    output logic [1:0]         direct_o,
    output logic               step_o,
    output logic               long_rst_o
);

    // Debounce counter never exceeds DB_CYCLES-1.
    localparam int DBW     = $clog2(DB_CYCLES);
    localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int RPTW    = $clog2(RPT_MAX + 1);
    localparam int LW      = $clog2(LONG_CYCLES + 1);

    localparam logic [DBW-1:0]  DB_LAST  = DBW'(DB_CYCLES - 1);
    localparam logic [RPTW-1:0] RPT_DLY  = RPTW'(RPT_DELAY);
    localparam logic [RPTW-1:0] RPT_PER  = RPTW'(RPT_PERIOD);
    localparam logic [RPTW-1:0] RPT_SAT  = RPTW'(RPT_MAX);
    localparam logic [LW-1:0]   LONG_MAX = LW'(LONG_CYCLES);

    // ------------------------------------------------------------------
    // Two-flop synchronizer
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_i;
            sync2 <= sync1;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel debounce. A channel flips once the synchronized value
    // has disagreed with the debounced level for DB_CYCLES consecutive
    // cycles; any agreeing cycle restarts the count.
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] flip;
    logic [NUM_BTN-1:0] db_nxt;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic [DBW-1:0] cnt;

        assign flip[i] = (sync2[i] != btn_db_o[i]) && (cnt == DB_LAST);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if ((sync2[i] == btn_db_o[i]) || flip[i]) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign db_nxt = btn_db_o ^ flip;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_db_o  <= '0;
            press_o   <= '0;
            release_o <= '0;
        end else begin
            btn_db_o  <= db_nxt;
            press_o   <= flip & ~btn_db_o;
            release_o <= flip & btn_db_o;
        end
    end

    // ------------------------------------------------------------------
    // Direction decode: only a single held direction is a valid move.
    // ------------------------------------------------------------------
    logic       move_nxt;
    logic [1:0] dir_nxt;

    always_comb begin
        move_nxt = 1'b1;
        dir_nxt  = `DOWN;
        case (btn_db_o[3:0])
            4'b0001: dir_nxt  = `DOWN;
            4'b0010: dir_nxt  = `UP;
            4'b0100: dir_nxt  = `RIGHT;
            4'b1000: dir_nxt  = `LEFT;
            default: move_nxt = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Step / auto-repeat. rpt_phase selects the initial delay (0) or the
    // steady repeat period (1); the counter measures cycles since the
    // last step pulse.
    // ------------------------------------------------------------------
    logic [RPTW-1:0] rpt_cnt;
    logic [RPTW-1:0] rpt_cnt_inc;
    logic [RPTW-1:0] rpt_target;
    logic            rpt_phase;
    logic            new_dir;
    logic            hold_dir;

    assign new_dir     = move_nxt && (!move_en_o || (dir_nxt != direct_o));
    assign hold_dir    = move_nxt && move_en_o && (dir_nxt == direct_o);
    assign rpt_cnt_inc = rpt_cnt + 1'b1;
    assign rpt_target  = rpt_phase ? RPT_PER : RPT_DLY;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            move_en_o <= 1'b0;
            direct_o  <= `DOWN;
            step_o    <= 1'b0;
            rpt_cnt   <= '0;
            rpt_phase <= 1'b0;
        end else begin
            move_en_o <= move_nxt;
            direct_o  <= dir_nxt;
            if (hold_dir) begin
                if (rpt_cnt_inc == rpt_target) begin
                    step_o    <= 1'b1;
                    rpt_cnt   <= '0;
                    rpt_phase <= 1'b1;
                end else begin
                    step_o <= 1'b0;
                    if (rpt_cnt != RPT_SAT) begin
                        rpt_cnt <= rpt_cnt_inc;
                    end
                end
            end else begin
                step_o    <= new_dir;
                rpt_cnt   <= '0;
                rpt_phase <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Long-press. The counter follows db_nxt so its value during a cycle
    // equals the number of debounced-high cycles up to and including it.
    // ------------------------------------------------------------------
    logic [LW-1:0] long_cnt;
    logic          long_at_max;
    logic          long_seen_q;

    assign long_at_max = (long_cnt == LONG_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            long_cnt    <= '0;
            long_seen_q <= 1'b0;
        end else begin
            if (!db_nxt[LONG_IDX]) begin
                long_cnt <= '0;
            end else if (!long_at_max) begin
                long_cnt <= long_cnt + 1'b1;
            end
            long_seen_q <= long_at_max;
        end
    end

    // Pulse mode fires only on the first cycle at the saturated value.
    assign long_rst_o = long_at_max && ((RST_MODE == 0) || !long_seen_q);

endmodule

// File: tb/tb_btn_debounce_enc.sv
`ifndef UP
`define UP    2'b00
`endif
`ifndef DOWN
`define DOWN  2'b01
`endif
`ifndef LEFT
`define LEFT  2'b10
`endif
`ifndef RIGHT
`define RIGHT 2'b11
`endif

module tb_btn_debounce_enc;

    localparam int NB   = 5;
    localparam int DB   = 8;
    localparam int LONG = 16;
    localparam int RDLY = 20;
    localparam int RPER = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NB-1:0] btn_i = '0;

    logic [NB-1:0] db0, pr0, rl0, db1, pr1, rl1;
    logic mv0, st0, lr0, mv1, st1, lr1;
    logic [1:0] dr0, dr1;

    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    btn_debounce_enc #(.NUM_BTN(NB), .DB_CYCLES(DB), .LONG_CYCLES(LONG), .LONG_IDX(4),
                       .RPT_DELAY(RDLY), .RPT_PERIOD(RPER), .RST_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .btn_i(btn_i), .btn_db_o(db0), .press_o(pr0),
        .release_o(rl0), .move_en_o(mv0), .direct_o(dr0), .step_o(st0), .long_rst_o(lr0));

    btn_debounce_enc #(.NUM_BTN(NB), .DB_CYCLES(DB), .LONG_CYCLES(LONG), .LONG_IDX(4),
                       .RPT_DELAY(RDLY), .RPT_PERIOD(RPER), .RST_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .btn_i(btn_i), .btn_db_o(db1), .press_o(pr1),
        .release_o(rl1), .move_en_o(mv1), .direct_o(dr1), .step_o(st1), .long_rst_o(lr1));

    // ------------------------------------------------------------------
    // Reference model: raw delay line, run-length of disagreement,
    // time-since-first-step for repeats, consecutive-high count for hold.
    // ------------------------------------------------------------------
    logic [NB-1:0] m_r1 = '0, m_r2 = '0, m_db = '0, m_press = '0, m_rel = '0;
    logic          m_move = 1'b0, m_step = 1'b0, m_l0 = 1'b0, m_l1 = 1'b0;
    logic [1:0]    m_dir = `DOWN;
    int            m_run [NB];
    int            m_cyc = 0, m_t0 = 0, m_hc = 0, mt_el = 0;
    logic [NB-1:0] mt_seen, mt_old, mt_nd;
    logic [2:0]    mt_dec;

    function automatic logic [2:0] ref_dec(input logic [3:0] d);
        case (d)
            4'b0001: return {1'b1, `DOWN};
            4'b0010: return {1'b1, `UP};
            4'b0100: return {1'b1, `RIGHT};
            4'b1000: return {1'b1, `LEFT};
            default: return {1'b0, `DOWN};
        endcase
    endfunction

    initial begin
        for (int i = 0; i < NB; i++) m_run[i] = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_r1 = '0; m_r2 = '0; m_db = '0; m_press = '0; m_rel = '0;
                m_move = 1'b0; m_dir = `DOWN; m_step = 1'b0;
                m_hc = 0; m_l0 = 1'b0; m_l1 = 1'b0;
                for (int i = 0; i < NB; i++) m_run[i] = 0;
            end else begin
                mt_seen = m_r2;
                m_r2    = m_r1;
                m_r1    = btn_i;
                mt_old  = m_db;
                mt_nd   = m_db;
                for (int i = 0; i < NB; i++) begin
                    if (mt_seen[i] != m_db[i]) begin
                        m_run[i]++;
                        if (m_run[i] == DB) begin
                            mt_nd[i] = ~m_db[i];
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
                m_press = mt_nd & ~mt_old;
                m_rel   = ~mt_nd & mt_old;
                mt_dec  = ref_dec(mt_old[3:0]);
                m_cyc++;
                if (mt_dec[2] && (!m_move || mt_dec[1:0] != m_dir)) begin
                    m_step = 1'b1;
                    m_t0   = m_cyc;
                end else if (mt_dec[2]) begin
                    mt_el  = m_cyc - m_t0;
                    m_step = (mt_el == RDLY) || (mt_el > RDLY && ((mt_el - RDLY) % RPER) == 0);
                end else begin
                    m_step = 1'b0;
                end
                m_move = mt_dec[2];
                m_dir  = mt_dec[1:0];
                m_db   = mt_nd;
                m_hc   = mt_nd[4] ? m_hc + 1 : 0;
                m_l0   = (m_hc >= LONG);
                m_l1   = (m_hc == LONG);
            end
        end
    end

    task automatic idle(input int n);
        btn_i = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        nvec++; if ({db0, pr0, rl0, mv0, st0, lr0} !== '0) begin nfail++;
            $display("FAIL reset_zero got=%h exp=0", {db0, pr0, rl0, mv0, st0, lr0}); end
        nvec++; if (dr0 !== `DOWN) begin nfail++;
            $display("FAIL reset_dir got=%b exp=%b", dr0, `DOWN); end
        nvec++; if ({db1, pr1, rl1, mv1, st1, lr1, dr1} !== {20'h0, `DOWN}) begin nfail++;
            $display("FAIL reset_dut1 got=%h", {db1, pr1, rl1, mv1, st1, lr1, dr1}); end
        rst = 1'b0;
        idle(15);
    endtask

    task automatic test_press();
        btn_i = 5'b00001;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            nvec++; if (pr0 !== ((c == 10) ? 5'b00001 : 5'b00000)) begin nfail++;
                $display("FAIL press_pulse c=%0d got=%b", c, pr0); end
            nvec++; if (db0[0] !== 1'(c >= 10)) begin nfail++;
                $display("FAIL press_db c=%0d got=%b exp=%b", c, db0[0], c >= 10); end
            nvec++; if (mv0 !== 1'(c >= 11)) begin nfail++;
                $display("FAIL press_move c=%0d got=%b exp=%b", c, mv0, c >= 11); end
            nvec++; if (st0 !== 1'(c == 11)) begin nfail++;
                $display("FAIL press_step c=%0d got=%b exp=%b", c, st0, c == 11); end
            nvec++; if (dr0 !== `DOWN) begin nfail++;
                $display("FAIL press_dir c=%0d got=%b exp=%b", c, dr0, `DOWN); end
        end
        idle(15);
    endtask

    task automatic test_glitch();
        btn_i = 5'b00100;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c == 5) btn_i = '0;
            nvec++; if ({db0, pr0, st0} !== 11'h0) begin nfail++;
                $display("FAIL glitch c=%0d got db=%b press=%b step=%b exp 0", c, db0, pr0, st0); end
        end
        idle(5);
    endtask

    task automatic test_repeat();
        bit ok;
        btn_i = 5'b00010;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            nvec++; if (st0 !== 1'(c == 11 || c == 31 || c == 37 || c == 43)) begin nfail++;
                $display("FAIL repeat_step c=%0d got=%b", c, st0); end
            if (c >= 11) begin
                nvec++; if (dr0 !== `UP || mv0 !== 1'b1) begin nfail++;
                    $display("FAIL repeat_dir c=%0d got mv=%b dir=%b exp 1/%b", c, mv0, dr0, `UP); end
            end
        end
        btn_i = '0;
        ok = 1'b0;
        for (int c = 0; c < 30 && !ok; c++) begin
            @(negedge clk);
            ok = (mv0 == 1'b0);
        end
        nvec++; if (!ok) begin nfail++; $display("FAIL repeat_release_timeout move_en still 1"); end
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            nvec++; if (st0 !== 1'b0) begin nfail++;
                $display("FAIL repeat_after_release c=%0d got=%b exp=0", c, st0); end
        end
        idle(10);
    endtask

    task automatic test_conflict();
        btn_i = 5'b01001;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            nvec++; if ({mv0, st0, dr0} !== {2'b00, `DOWN}) begin nfail++;
                $display("FAIL conflict c=%0d got mv=%b st=%b dir=%b", c, mv0, st0, dr0); end
        end
        nvec++; if (db0[3:0] !== 4'b1001) begin nfail++;
            $display("FAIL conflict_db got=%b exp=1001", db0[3:0]); end
        idle(15);
    endtask

    task automatic test_long();
        btn_i = 5'b10000;
        for (int c = 1; c <= 55; c++) begin
            @(negedge clk);
            if (c == 40) btn_i = '0;
            nvec++; if (lr0 !== 1'(c >= 25 && c < 50)) begin nfail++;
                $display("FAIL long_level c=%0d got=%b", c, lr0); end
            nvec++; if (lr1 !== 1'(c == 25)) begin nfail++;
                $display("FAIL long_pulse c=%0d got=%b", c, lr1); end
            nvec++; if ({pr0[4], rl0[4]} !== {1'(c == 10), 1'(c == 50)}) begin nfail++;
                $display("FAIL long_edges c=%0d got press=%b rel=%b", c, pr0[4], rl0[4]); end
        end
        idle(15);
    endtask

    task automatic test_reset_mid();
        btn_i = 5'b10000;
        repeat (30) @(negedge clk);
        btn_i = 5'b10001;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        nvec++; if ({db0, pr0, rl0, mv0, st0, lr0, dr0} !== {20'h0, `DOWN}) begin nfail++;
            $display("FAIL rstmid_async got=%h", {db0, pr0, rl0, mv0, st0, lr0, dr0}); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            nvec++; if (pr0 !== ((c == 10) ? 5'b10001 : 5'b00000)) begin nfail++;
                $display("FAIL rstmid_press c=%0d got=%b", c, pr0); end
            nvec++; if (db0 !== ((c >= 10) ? 5'b10001 : 5'b00000)) begin nfail++;
                $display("FAIL rstmid_db c=%0d got=%b", c, db0); end
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 70; s++) begin
            int k;
            int len;
            k = $urandom_range(0, 3);
            case (k)
                0: begin btn_i = '0; btn_i[$urandom_range(0, 3)] = 1'b1; end
                1: btn_i = 5'($urandom);
                2: btn_i = '0;
                default: btn_i[$urandom_range(0, 4)] = ~btn_i[$urandom_range(0, 4)];
            endcase
            len = (k == 1) ? $urandom_range(1, 12) : $urandom_range(3, 70);
            repeat (len) begin
                @(negedge clk);
                nvec++;
                if ({db0, pr0, rl0, mv0, dr0, st0, lr0} !== {m_db, m_press, m_rel, m_move, m_dir, m_step, m_l0}) begin
                    nfail++;
                    $display("FAIL rnd_dut0 t=%0t got=%h exp=%h", $time,
                             {db0, pr0, rl0, mv0, dr0, st0, lr0}, {m_db, m_press, m_rel, m_move, m_dir, m_step, m_l0});
                end
                nvec++;
                if ({db1, pr1, rl1, mv1, dr1, st1, lr1} !== {m_db, m_press, m_rel, m_move, m_dir, m_step, m_l1}) begin
                    nfail++;
                    $display("FAIL rnd_dut1 t=%0t got=%h exp=%h", $time,
                             {db1, pr1, rl1, mv1, dr1, st1, lr1}, {m_db, m_press, m_rel, m_move, m_dir, m_step, m_l1});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_repeat();
        test_conflict();
        test_long();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/btn_debounce_enc.md
BTN_DEBOUNCE_ENC -- requirements
Module: btn_debounce_enc

Interface
REQ-001 SHALL have parameter NUM_BTN, default 5, giving the raw button count (must be >= 5); bits [3:0] are D,U,R,L and bit LONG_IDX is the hold button.
REQ-002 SHALL have parameter DB_CYCLES, default 1_000_000, giving the debounce stability window in clk cycles (must be >= 2).
REQ-003 SHALL have parameter LONG_CYCLES, default 50_000_000, giving the hold time in clk cycles before long_rst_o fires (must be >= 1).
REQ-004 SHALL have parameter LONG_IDX, default 4, giving the index of the long-press button (must be >= 4 and < NUM_BTN).
REQ-005 SHALL have parameter RPT_DELAY, default 25_000_000, giving the number of cycles from the first step pulse to the first auto-repeat pulse.
REQ-006 SHALL have parameter RPT_PERIOD, default 5_000_000, giving the number of cycles between later auto-repeat pulses.
REQ-007 SHALL have parameter RST_MODE, default 0: 0 makes long_rst_o a level held while the button is held; 1 makes it a single-cycle pulse.
REQ-008 SHALL have port clk, input, 1 bit: the single system clock.
REQ-009 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-010 SHALL have port btn_i, input, NUM_BTN bits: raw board pins, asynchronous to clk, active-high.
REQ-011 SHALL have port btn_db_o, output, NUM_BTN bits: debounced button levels.
REQ-012 SHALL have port press_o, output, NUM_BTN bits: one-cycle pulse per channel on a debounced 0->1 transition.
REQ-013 SHALL have port release_o, output, NUM_BTN bits: one-cycle pulse per channel on a debounced 1->0 transition.
REQ-014 SHALL have port move_en_o, output, 1 bit: level, high while exactly one direction button is debounced-high.
REQ-015 SHALL have port direct_o, output, 2 bits: the codebase `UP/`DOWN/`LEFT/`RIGHT encoding.
REQ-016 SHALL have port step_o, output, 1 bit: one-cycle movement step pulse with auto-repeat.
REQ-017 SHALL have port long_rst_o, output, 1 bit: long-press request, level or pulse per RST_MODE.

Function
REQ-018 Each channel SHALL pass btn_i through a 2-flop synchronizer before any other logic.
REQ-019 Each channel SHALL keep a debounce counter: sync == btn_db -> counter 0; sync != btn_db -> counter +1; the flip SHALL happen on the cycle the counter would reach DB_CYCLES-1.
REQ-020 On a flip, the channel SHALL toggle btn_db_o, clear the counter to 0, and raise press_o or release_o for that cycle only.
REQ-021 Latency from a clean raw edge to the btn_db_o change SHALL be exactly DB_CYCLES+2 cycles.
REQ-022 Any glitch shorter than DB_CYCLES cycles SHALL produce no output change, because a returned sync value clears the counter.
REQ-023 Channels SHALL operate independently; simultaneous flips on several channels SHALL all be reported in the same cycle.
REQ-024 Direction decode over btn_db_o[3:0]: 0001 -> `DOWN, 0010 -> `UP, 0100 -> `RIGHT, 1000 -> `LEFT, each with move_en_o=1; every other pattern SHALL give move_en_o=0 and direct_o=`DOWN.
REQ-025 move_en_o and direct_o SHALL be registered, updating one cycle after btn_db_o.
REQ-026 step_o SHALL pulse in the same cycle that move_en_o rises, and in the cycle a new valid single direction replaces an old one.
REQ-027 While move_en_o stays high with direct_o unchanged, further step_o pulses SHALL occur RPT_DELAY cycles after the first pulse, then every RPT_PERIOD cycles.
REQ-028 The repeat counter SHALL clear whenever move_en_o is 0 or direct_o changes, and SHALL saturate rather than wrap.
REQ-029 The long-press counter SHALL count cycles with btn_db_o[LONG_IDX]=1, SHALL saturate at LONG_CYCLES, and SHALL clear to 0 when that bit is 0.
REQ-030 With RST_MODE=0, long_rst_o SHALL be high in every cycle in which the long-press counter equals LONG_CYCLES.
REQ-031 With RST_MODE=1, long_rst_o SHALL pulse once, on the cycle the counter first reaches LONG_CYCLES; further holding SHALL produce no pulse until release followed by a new full hold.
REQ-032 The long-press button SHALL still generate press_o and release_o.
REQ-033 All counter widths SHALL be $clog2(max count + 1); no counter SHALL overflow.

Reset
REQ-034 Asserting rst SHALL immediately clear, independent of clk: synchronizers, btn_db_o, all counters, press_o, release_o, move_en_o, step_o and long_rst_o to 0, and set direct_o to `DOWN.
REQ-035 Asserting rst mid-debounce or mid-hold SHALL discard the partial count; after release, a still-held button SHALL need a full DB_CYCLES+2 cycles before press_o.
REQ-036 The block SHALL not drive the system reset itself; long_rst_o is a request consumed by the top level.

Verification
REQ-037 Scenario, with DB_CYCLES=8: btn_i[0] raised cleanly -> press_o[0] pulses exactly at cycle 10, btn_db_o[0]=1; then move_en_o=1, direct_o=`DOWN, and step_o pulses once, one cycle later.
REQ-038 Scenario: btn_i[2] glitched high for 5 cycles with DB_CYCLES=8 -> btn_db_o, press_o and step_o all stay 0.
REQ-039 Scenario, with RPT_DELAY=20 and RPT_PERIOD=6: btn_i[1] held -> step_o at t0, t0+20, t0+26, t0+32; on release, no further pulses.
REQ-040 Scenario: btn_i[0] and btn_i[3] both held -> move_en_o=0, direct_o=`DOWN, step_o never pulses.
REQ-041 Scenario, with LONG_CYCLES=16: btn_i[4] held, run once with RST_MODE=0 and once with RST_MODE=1 -> level high from the 16th debounced-high cycle until release (mode 0); exactly one pulse (mode 1).
REQ-042 Scenario: rst asserted at debounce count 5 on a held button -> all outputs 0 at once; after rst release, press_o arrives DB_CYCLES+2 cycles later.
